// File: rtl/dual_issue_sched.sv
// dual_issue_sched: 4-entry issue window in front of the dual-issue decoder.
// The oldest two queued instructions are presented as an issue pair. One or
// two of them are consumed per cycle, depending on the decoder's verdict and
// the execute stall.
// Optional build macro DUAL_ISSUE_SCHED_STATS_EN adds saturating
// dual/single issue counters (stat_dual_o, stat_single_o).
// Handshake: fetch data is taken on a cycle where fetch_ready_o & fetch_v_i[0];
// the head pair is consumed on a cycle where dec_v_o[0] & issue_ready_i &
// !flush_i, and issue_count_o reports how many instructions left the window.
module dual_issue_sched #(
    parameter int instr_width_p = 32,
    parameter int pc_width_p    = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [1:0]                 fetch_v_i,
    input  logic [2*instr_width_p-1:0] fetch_instr_i,
    input  logic [pc_width_p-1:0]      fetch_pc_i,
    output logic                       fetch_ready_o,
    output logic [1:0]                 dec_v_o,
    output logic [2*instr_width_p-1:0] dec_instr_o,
    output logic [2*pc_width_p-1:0]    dec_pc_o,
    input  logic                       single_issue_i,
    input  logic                       issue_ready_i,
    output logic [1:0]                 issue_count_o,
    input  logic                       flush_i
`ifdef DUAL_ISSUE_SCHED_STATS_EN
    ,
    output logic [31:0]                stat_dual_o,
    output logic [31:0]                stat_single_o
`endif
);

    logic [instr_width_p-1:0] r_instr [4];
    logic [pc_width_p-1:0]    r_pc    [4];
    logic [1:0]               r_head;
    logic [1:0]               r_tail;
    logic [2:0]               r_count;

    logic [1:0]               w_head1;
    logic [1:0]               w_tail1;
    logic                     w_enq;
    logic [1:0]               w_enq_n;
    logic                     w_issue;
    logic [2:0]               w_count_next;

    assign w_head1 = r_head + 2'd1;
    assign w_tail1 = r_tail + 2'd1;

    // Ready comes from registered occupancy only, so a dequeue in the same
    // cycle never opens room for a fetch; this keeps fetch off the decoder path.
    assign fetch_ready_o = !reset_i && !flush_i && (r_count <= 3'd2);

    // Illegal mask 2'b10 has bit 0 clear and is therefore dropped here.
    assign w_enq   = fetch_ready_o && fetch_v_i[0];
    assign w_enq_n = !w_enq ? 2'd0 : (fetch_v_i[1] ? 2'd2 : 2'd1);

    // Issue pair presentation; empty slots drive zeros.
    always_comb begin
        dec_v_o     = {r_count >= 3'd2, r_count >= 3'd1};
        dec_instr_o = '0;
        dec_pc_o    = '0;
        if (dec_v_o[0]) begin
            dec_instr_o[instr_width_p-1:0] = r_instr[r_head];
            dec_pc_o[pc_width_p-1:0]       = r_pc[r_head];
        end
        if (dec_v_o[1]) begin
            dec_instr_o[2*instr_width_p-1:instr_width_p] = r_instr[w_head1];
            dec_pc_o[2*pc_width_p-1:pc_width_p]          = r_pc[w_head1];
        end
    end

    // Consumption count: a lone entry always issues alone.
    assign w_issue = dec_v_o[0] && issue_ready_i && !flush_i;
    always_comb begin
        issue_count_o = 2'd0;
        if (w_issue) begin
            issue_count_o = (dec_v_o[1] && !single_issue_i) ? 2'd2 : 2'd1;
        end
    end

    assign w_count_next = r_count + {1'b0, w_enq_n} - {1'b0, issue_count_o};

    // Pointer and occupancy update; flush empties the window and realigns to 0.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
        end else if (flush_i) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            r_head  <= r_head + issue_count_o;
            r_tail  <= r_tail + w_enq_n;
            r_count <= w_count_next;
        end
    end

    // Entry storage; contents of empty slots are never observed.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_instr[r_tail] <= fetch_instr_i[instr_width_p-1:0];
            r_pc[r_tail]    <= fetch_pc_i;
            if (fetch_v_i[1]) begin
                r_instr[w_tail1] <= fetch_instr_i[2*instr_width_p-1:instr_width_p];
                r_pc[w_tail1]    <= fetch_pc_i + pc_width_p'(4);
            end
        end
    end

`ifdef DUAL_ISSUE_SCHED_STATS_EN
    logic [31:0] r_stat_dual;
    logic [31:0] r_stat_single;

    // Saturating issue-width counters; intentionally untouched by flush.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stat_dual   <= 32'd0;
            r_stat_single <= 32'd0;
        end else begin
            if (issue_count_o == 2'd2 && r_stat_dual != 32'hFFFF_FFFF)
                r_stat_dual <= r_stat_dual + 32'd1;
            if (issue_count_o == 2'd1 && r_stat_single != 32'hFFFF_FFFF)
                r_stat_single <= r_stat_single + 32'd1;
        end
    end

    assign stat_dual_o   = r_stat_dual;
    assign stat_single_o = r_stat_single;
`endif

endmodule

// File: tb/tb_dual_issue_sched.sv
// tb_dual_issue_sched: directed test-plan scenarios plus randomized traffic,
// each cycle compared against a queue-based reference of the issue window.
// Honours DUAL_ISSUE_SCHED_STATS_EN when the design is built with it.
module tb_dual_issue_sched;
    localparam int IW = 32;
    localparam int PW = 32;

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b1;
    logic [1:0]      fetch_v_i = 2'b00;
    logic [2*IW-1:0] fetch_instr_i = '0;
    logic [PW-1:0]   fetch_pc_i = '0;
    logic            fetch_ready_o;
    logic [1:0]      dec_v_o;
    logic [2*IW-1:0] dec_instr_o;
    logic [2*PW-1:0] dec_pc_o;
    logic            single_issue_i = 1'b0;
    logic            issue_ready_i = 1'b0;
    logic [1:0]      issue_count_o;
    logic            flush_i = 1'b0;
`ifdef DUAL_ISSUE_SCHED_STATS_EN
    logic [31:0]     stat_dual_o;
    logic [31:0]     stat_single_o;
`endif

    dual_issue_sched #(.instr_width_p(IW), .pc_width_p(PW)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .fetch_v_i      (fetch_v_i),
        .fetch_instr_i  (fetch_instr_i),
        .fetch_pc_i     (fetch_pc_i),
        .fetch_ready_o  (fetch_ready_o),
        .dec_v_o        (dec_v_o),
        .dec_instr_o    (dec_instr_o),
        .dec_pc_o       (dec_pc_o),
        .single_issue_i (single_issue_i),
        .issue_ready_i  (issue_ready_i),
        .issue_count_o  (issue_count_o),
        .flush_i        (flush_i)
`ifdef DUAL_ISSUE_SCHED_STATS_EN
        ,
        .stat_dual_o    (stat_dual_o),
        .stat_single_o  (stat_single_o)
`endif
    );

    // clock / reset block
    always #5 clk_i = ~clk_i;

    // scoreboard: each entry is {instr, pc}, oldest at index 0
    logic [IW+PW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int exp_dual   = 0;
    int exp_single = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare combinational
    // outputs against the reference, then advance the reference at the edge.
    task automatic step(input logic [1:0] fv, input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                        input logic [PW-1:0] pc, input logic sg, input logic rdy, input logic fl);
        int n;
        logic            e_ready;
        logic [1:0]      e_v;
        logic [1:0]      e_cnt;
        logic [IW-1:0]   e_i0, e_i1;
        logic [PW-1:0]   e_p0, e_p1;
        @(negedge clk_i);
        fetch_v_i      = fv;
        fetch_instr_i  = {i1, i0};
        fetch_pc_i     = pc;
        single_issue_i = sg;
        issue_ready_i  = rdy;
        flush_i        = fl;
        #1;
        n       = exp_q.size();
        e_ready = !fl && (n <= 2);
        e_v     = {n >= 2, n >= 1};
        e_i0 = '0; e_p0 = '0; e_i1 = '0; e_p1 = '0;
        if (n >= 1) begin e_i0 = exp_q[0][IW+PW-1:PW]; e_p0 = exp_q[0][PW-1:0]; end
        if (n >= 2) begin e_i1 = exp_q[1][IW+PW-1:PW]; e_p1 = exp_q[1][PW-1:0]; end
        if (n >= 1 && rdy && !fl) e_cnt = (n >= 2 && !sg) ? 2'd2 : 2'd1;
        else                      e_cnt = 2'd0;
        check("fetch_ready", 64'(fetch_ready_o), 64'(e_ready));
        check("dec_v",       64'(dec_v_o),       64'(e_v));
        check("dec_instr0",  64'(dec_instr_o[IW-1:0]),    64'(e_i0));
        check("dec_instr1",  64'(dec_instr_o[2*IW-1:IW]), 64'(e_i1));
        check("dec_pc0",     64'(dec_pc_o[PW-1:0]),       64'(e_p0));
        check("dec_pc1",     64'(dec_pc_o[2*PW-1:PW]),    64'(e_p1));
        check("issue_count", 64'(issue_count_o), 64'(e_cnt));
        if (e_cnt == 2'd2 && exp_dual   != 32'hFFFF_FFFF) exp_dual++;
        if (e_cnt == 2'd1 && exp_single != 32'hFFFF_FFFF) exp_single++;
        if (fl) begin
            exp_q.delete();
        end else begin
            for (int k = 0; k < int'(e_cnt); k++) void'(exp_q.pop_front());
            if (e_ready && fv[0]) begin
                exp_q.push_back({i0, pc});
                if (fv[1]) exp_q.push_back({i1, pc + PW'(4)});
            end
        end
    endtask

    task automatic idle(input logic sg, input logic rdy);
        step(2'b00, '0, '0, '0, sg, rdy, 1'b0);
    endtask

    // Asynchronous reset pulse, checked while held and after release.
    task automatic do_reset();
        @(negedge clk_i);
        fetch_v_i     = 2'b11;
        issue_ready_i = 1'b1;
        flush_i       = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        check("rst_dec_v",       64'(dec_v_o),       64'd0);
        check("rst_issue_count", 64'(issue_count_o), 64'd0);
        check("rst_fetch_ready", 64'(fetch_ready_o), 64'd0);
        @(negedge clk_i);
        fetch_v_i = 2'b00;
        reset_i   = 1'b0;
        #1;
        check("post_rst_ready",  64'(fetch_ready_o), 64'd1);
        check("post_rst_dec_v",  64'(dec_v_o),       64'd0);
        exp_q.delete();
        exp_dual   = 0;
        exp_single = 0;
    endtask

    task automatic check_stats(input string tag);
`ifdef DUAL_ISSUE_SCHED_STATS_EN
        check({tag, "_dual"},   64'(stat_dual_o),   64'(exp_dual));
        check({tag, "_single"}, 64'(stat_single_o), 64'(exp_single));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        int next;
        logic [1:0] fv;
        do_reset();

        // first pair dual-issues one cycle after fetch
        step(2'b11, 32'h0010_0093, 32'h0020_0113, 32'h100, 1'b0, 1'b1, 1'b0);
        check("tp1_pc0", 64'(dec_pc_o[PW-1:0]), 64'h0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);

        // three back-to-back pairs drained one per cycle
        next = 0;
        for (int c = 0; c < 12; c++) begin
            if (next < 3 && exp_q.size() <= 2) begin
                step(2'b11, $urandom, $urandom, PW'(next * 8), 1'b1, 1'b1, 1'b0);
                next++;
            end else begin
                idle(1'b1, 1'b1);
            end
        end

        // stall fills the window to 4, then release
        step(2'b11, $urandom, $urandom, 32'h200, 1'b0, 1'b0, 1'b0);
        step(2'b11, $urandom, $urandom, 32'h208, 1'b0, 1'b0, 1'b0);
        step(2'b11, $urandom, $urandom, 32'h210, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) idle(1'b0, 1'b1);

        // lone entry issues alone even with dual verdict
        step(2'b01, $urandom, $urandom, 32'h300, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b1);

        // flush with count=3 and a same-cycle fetch
        step(2'b11, $urandom, $urandom, 32'h400, 1'b0, 1'b0, 1'b0);
        step(2'b01, $urandom, $urandom, 32'h408, 1'b0, 1'b0, 1'b0);
        step(2'b11, $urandom, $urandom, 32'h500, 1'b0, 1'b1, 1'b1);
        idle(1'b0, 1'b1);

        // illegal mask 2'b10 is dropped
        step(2'b10, $urandom, $urandom, 32'h600, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b1);

        // 5 dual then 3 single issues from a clean reset
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step(2'b11, $urandom, $urandom, PW'(c * 8), 1'b0, 1'b0, 1'b0);
            idle(1'b0, 1'b1);
        end
        for (int c = 0; c < 3; c++) begin
            step(2'b01, $urandom, $urandom, PW'(c * 4), 1'b0, 1'b0, 1'b0);
            idle(1'b0, 1'b1);
        end
`ifdef DUAL_ISSUE_SCHED_STATS_EN
        check("tp_stat_dual",   64'(stat_dual_o),   64'd5);
        check("tp_stat_single", 64'(stat_single_o), 64'd3);
`endif

        // randomized traffic with occasional flush and mid-run reset
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0:       fv = 2'b00;
                1:       fv = 2'b01;
                2:       fv = 2'b11;
                default: fv = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b11;
            endcase
            if (c == 300) begin
                check_stats("pre_reset");
                do_reset();
            end
            step(fv, $urandom, $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 24) == 0));
        end
        @(negedge clk_i);
        check_stats("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dual_issue_sched.md
# dual_issue_sched

Issue-window scheduler in front of the vanilla core's dual-issue decoder. Buffers fetched instructions in a 4-entry circular queue, presents the oldest two as an issue pair to the dual decoder, and consumes one or two per cycle depending on the decoder's single-issue verdict and the execute stage's stall. Sits between the fetch stage and decode/issue, replacing the single-instruction fetch register for dual-issue builds.

## Interface
- `instr_width_p`, 32, instruction width in bits.
- `pc_width_p`, 32, PC width in bits; PCs are byte addresses, one instruction = 4 bytes.
- `clk_i`  in  1  core clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `fetch_v_i`  in  2  per-slot fetch valid mask; legal values 2'b00, 2'b01, 2'b11.
- `fetch_instr_i`  in  2×`instr_width_p`  fetched instructions; index 0 is the older.
- `fetch_pc_i`  in  `pc_width_p`  PC of fetch slot 0; slot 1 PC is `fetch_pc_i`+4.
- `fetch_ready_o`  out  1  queue can accept a fetch this cycle.
- `dec_v_o`  out  2  issue-pair valid mask to decoder.
- `dec_instr_o`  out  2×`instr_width_p`  head and head+1 instructions.
- `dec_pc_o`  out  2×`pc_width_p`  PCs of head and head+1.
- `single_issue_i`  in  1  decoder's single-issue verdict for the current pair.
- `issue_ready_i`  in  1  execute stage can accept an issue this cycle.
- `issue_count_o`  out  2  instructions consumed this cycle: 0, 1 or 2.
- `flush_i`  in  1  discard all queued instructions (branch redirect, exception).

## Operation
- Storage: 4 entries of {instr, pc}; 2-bit head/tail pointers wrapping mod 4; 3-bit `count`, 0..4.
- `dec_v_o[0]` = count ≥ 1; `dec_v_o[1]` = count ≥ 2. Invalid slots drive zero instr and PC.
- `fetch_ready_o` = !flush_i & count ≤ 2, from registered count only; a same-cycle dequeue does not raise it.
- Enqueue when `fetch_ready_o` & `fetch_v_i[0]`: write slot 0 at tail, and slot 1 at tail+1 if `fetch_v_i[1]`; tail advances by popcount. Illegal mask 2'b10 is ignored (no enqueue).
- Issue when `dec_v_o[0]` & `issue_ready_i` & !flush_i:
  - `issue_count_o` = 2 if `dec_v_o[1]` & !`single_issue_i`, else 1.
  - count = 1 forces single issue regardless of `single_issue_i`.
  - Head advances by `issue_count_o`.
- Otherwise `issue_count_o` = 0.
- Simultaneous enqueue and issue: `count_next = count + enq_n − issue_count_o`; never exceeds 4 by construction.
- Flush: next cycle count = 0, head = tail = 0. Flush overrides enqueue and issue in the same cycle.
- `single_issue_i` is sampled only when `dec_v_o[1]`; it is otherwise don't-care.

## Timing
- Reset (asynchronous): count = 0, head = tail = 0. Outputs during and after reset: `dec_v_o` = 0, `issue_count_o` = 0, `fetch_ready_o` = 0 while `reset_i` is high and 1 once it falls.
- Fetch-to-decode latency is 1 cycle. An instruction enqueued in cycle N is visible on `dec_*_o` in N+1.
- `dec_*_o` and `fetch_ready_o` are functions of registered state only (plus `flush_i` gating on ready).
- `issue_count_o` is combinational from `single_issue_i` and `issue_ready_i`. The decoder path `dec_instr_o` → `single_issue_i` → `issue_count_o` is one combinational loop-free path.
- Reset asserted mid-operation clears the queue immediately; any pending fetch is lost.

## Configuration
- `DUAL_ISSUE_SCHED_STATS_EN` defined: adds outputs `stat_dual_o` and `stat_single_o`, both 32 bits, reset to 0.
  - They count cycles with `issue_count_o` = 2 and = 1 respectively.
  - They saturate at 32'hFFFF_FFFF and are not cleared by flush.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then fetch pair {0x00100093, 0x00200113} at PC 0x100 with `single_issue_i`=0 and `issue_ready_i`=1.
  - Next cycle: `dec_v_o`=2'b11, PCs 0x100/0x104, `issue_count_o`=2.
  - Following cycle: count=0.
- Three back-to-back pairs at PC 0x0, 0x8, 0x10 with `single_issue_i`=1 constantly.
  - One instruction issues per cycle and `fetch_ready_o` drops when count=3.
  - Issue PC order is 0x0, 0x4, 0x8, 0xC, 0x10, 0x14 with no loss.
- `issue_ready_i`=0 with a pair already queued, then a second pair fetched: count=4 and `fetch_ready_o`=0. Releasing the stall issues in order.
- With count=1 and `single_issue_i`=0: `issue_count_o`=1 and `dec_v_o[1]`=0.
- With count=3, assert `flush_i` in the same cycle as `fetch_v_i`=2'b11: nothing is enqueued or issued, and next cycle count=0 with `dec_v_o`=0.
- With `DUAL_ISSUE_SCHED_STATS_EN`, 5 dual issues followed by 3 single issues give `stat_dual_o`=5 and `stat_single_o`=3. Without the macro, the same bench compiles with no stat ports.
